// File: rtl/tc7_mod_accumulator.sv
// Streaming mod-7 accumulator over thermometer-coded residues; sums each frame
// and presents the residue, beat count and illegal-code flag through a 1-deep output buffer.
module tc7_mod_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:1]       in_tc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:1]       out_tc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic tc_legal(input logic [6:1] tc);
    return tc inside {6'b000000, 6'b000001, 6'b000011, 6'b000111,
                      6'b001111, 6'b011111, 6'b111111};
  endfunction

  // Illegal patterns decode to 0 so they leave the running residue untouched.
  function automatic logic [2:0] tc_decode(input logic [6:1] tc);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 1; i <= 6; i++) n = n + {2'b00, tc[i]};
    return tc_legal(tc) ? n : 3'd0;
  endfunction

  function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction

  function automatic logic [6:1] tc_encode(input logic [2:0] r);
    logic [6:1] t;
    for (int i = 1; i <= 6; i++) t[i] = (i <= int'(r));
    return t;
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [6:1]       out_tc_q, out_tc_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             accept, consume, cnt_sat, beat_err;
  logic [2:0]       acc_sum;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = ~out_valid_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign consume   = (state_q == HOLD) & out_ready;

  assign cnt_sat   = (cnt_q == CNT_MAX);
  assign cnt_inc   = cnt_sat ? cnt_q : cnt_q + 1'b1;
  assign beat_err  = ~tc_legal(in_tc) | cnt_sat;
  assign acc_sum   = mod7_add(acc_q, tc_decode(in_tc));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_tc_d    = out_tc_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;

    if (consume) begin
      out_valid_d = 1'b0;
      state_d     = ACC;
    end

    // acc/cnt/err are already zero whenever a beat lands in HOLD, so a
    // same-cycle consume+accept naturally starts the next frame from zero.
    if (accept) begin
      if (in_last) begin
        out_tc_d    = tc_encode(acc_sum);
        out_count_d = cnt_inc;
        out_err_d   = err_q | beat_err;
        out_valid_d = 1'b1;
        state_d     = HOLD;
        acc_d       = 3'd0;
        cnt_d       = '0;
        err_d       = 1'b0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        err_d = err_q | beat_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= 3'd0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_tc_q    <= 6'b000000;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_tc_q    <= out_tc_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tc    = out_tc_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_tc7_mod_accumulator.sv
// Bench for tc7_mod_accumulator: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream and are compared against a frame-level arithmetic model.
module tb_tc7_mod_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:1] in_tc = 6'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_a, out_valid_a, out_err_a;
  logic [6:1] out_tc_a;
  logic [7:0] out_count_a;
  logic       in_ready_b, out_valid_b, out_err_b;
  logic [6:1] out_tc_b;
  logic [1:0] out_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tc7_mod_accumulator #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_tc(in_tc), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_tc(out_tc_a), .out_count(out_count_a),
    .out_err(out_err_a)
  );

  tc7_mod_accumulator #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_tc(in_tc), .in_last(in_last), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_tc(out_tc_b), .out_count(out_count_b),
    .out_err(out_err_b)
  );

  // Reference model: index 0 mirrors CNT_W=8, index 1 mirrors CNT_W=2.
  int         maxc [2] = '{255, 3};
  int         fsum [2];
  int         fn   [2];
  bit         fill [2];
  bit         ev;
  logic [6:1] etc  [2];
  int         ecnt [2];
  bit         eerr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:1] therm(input int k);
    logic [6:1] t;
    t = 6'((1 << k) - 1);
    return t;
  endfunction

  function automatic int tc_val(input logic [6:1] tc);
    for (int k = 0; k <= 6; k++) if (tc == therm(k)) return k;
    return -1;
  endfunction

  task automatic model_reset();
    ev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fsum[k] = 0; fn[k] = 0; fill[k] = 1'b0;
      etc[k] = 6'b0; ecnt[k] = 0; eerr[k] = 1'b0;
    end
  endtask

  task automatic model_update(input bit r, input bit v, input logic [6:1] tc,
                              input bit l, input bit o);
    bit acc;
    int val;
    if (r) begin
      model_reset();
    end else begin
      acc = v && (!ev || o);
      if (ev && o) ev = 1'b0;
      if (acc) begin
        val = tc_val(tc);
        for (int k = 0; k < 2; k++) begin
          if (val < 0) fill[k] = 1'b1;
          else fsum[k] += val;
          fn[k]++;
          if (l) begin
            etc[k]  = therm(fsum[k] % 7);
            ecnt[k] = (fn[k] > maxc[k]) ? maxc[k] : fn[k];
            eerr[k] = fill[k] || (fn[k] > maxc[k]);
            fsum[k] = 0; fn[k] = 0; fill[k] = 1'b0;
          end
        end
        if (l) ev = 1'b1;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [6:1] tc,
                      input bit l, input bit o);
    rst = r; in_valid = v; in_tc = tc; in_last = l; out_ready = o;
    #1;
    chk("in_ready_a", 32'(in_ready_a), 32'(!ev || o));
    chk("in_ready_b", 32'(in_ready_b), 32'(!ev || o));
    @(posedge clk);
    model_update(r, v, tc, l, o);
    @(negedge clk);
    chk("out_valid_a", 32'(out_valid_a), 32'(ev));
    chk("out_tc_a",    32'(out_tc_a),    32'(etc[0]));
    chk("out_count_a", 32'(out_count_a), 32'(ecnt[0]));
    chk("out_err_a",   32'(out_err_a),   32'(eerr[0]));
    chk("out_valid_b", 32'(out_valid_b), 32'(ev));
    chk("out_tc_b",    32'(out_tc_b),    32'(etc[1]));
    chk("out_count_b", 32'(out_count_b), 32'(ecnt[1]));
    chk("out_err_b",   32'(out_err_b),   32'(eerr[1]));
  endtask

  initial begin
    logic [6:1] t;
    bit v, l, o, r;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    step(1, 0, 6'b0, 0, 0);
    chk("reset_valid", 32'(out_valid_a), 32'd0);
    chk("reset_count", 32'(out_count_a), 32'd0);

    // 3+4+6 = 13 -> 6
    step(0, 1, 6'b000111, 0, 0);
    step(0, 1, 6'b001111, 0, 0);
    step(0, 1, 6'b111111, 1, 0);
    chk("f1_valid", 32'(out_valid_a), 32'd1);
    chk("f1_tc",    32'(out_tc_a),    32'h3f);
    chk("f1_count", 32'(out_count_a), 32'd3);
    chk("f1_err",   32'(out_err_a),   32'd0);
    step(0, 0, 6'b0, 0, 1);

    step(0, 1, 6'b111111, 0, 1);
    step(0, 1, 6'b000001, 1, 1);
    chk("f2_tc",    32'(out_tc_a),    32'h00);
    chk("f2_count", 32'(out_count_a), 32'd2);
    step(0, 0, 6'b0, 0, 1);

    step(0, 1, 6'b000011, 0, 1);
    step(0, 1, 6'b000011, 0, 1);
    step(0, 1, 6'b000011, 0, 1);
    step(0, 1, 6'b000001, 1, 1);
    chk("f3_tc",    32'(out_tc_a),    32'h00);
    chk("f3_count", 32'(out_count_a), 32'd4);
    step(0, 0, 6'b0, 0, 1);

    // illegal 000101 counts as a beat, contributes 0, flags error
    step(0, 1, 6'b000011, 0, 1);
    step(0, 1, 6'b000101, 0, 1);
    step(0, 1, 6'b000001, 1, 1);
    chk("ill_tc",    32'(out_tc_a),    32'h07);
    chk("ill_count", 32'(out_count_a), 32'd3);
    chk("ill_err",   32'(out_err_a),   32'd1);
    step(0, 1, 6'b000001, 1, 1);
    chk("clean_err", 32'(out_err_a),   32'd0);

    // backpressure: beats offered while held must be ignored
    for (int i = 0; i < 5; i++) step(0, 1, 6'b000111, 0, 0);
    step(0, 1, 6'b011111, 1, 1);
    chk("b2b_valid", 32'(out_valid_a), 32'd1);
    chk("b2b_tc",    32'(out_tc_a),    32'h1f);
    chk("b2b_count", 32'(out_count_a), 32'd1);
    step(0, 0, 6'b0, 0, 1);

    // reset mid-frame, then reset during HOLD
    step(0, 1, 6'b000111, 0, 1);
    step(0, 1, 6'b000111, 0, 1);
    step(1, 1, 6'b000111, 0, 1);
    step(0, 1, 6'b000001, 1, 1);
    chk("rstf_tc",    32'(out_tc_a),    32'h01);
    chk("rstf_count", 32'(out_count_a), 32'd1);
    step(1, 0, 6'b0, 0, 0);
    chk("rsth_valid", 32'(out_valid_a), 32'd0);

    // beat-counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) step(0, 1, 6'b000001, (i == 4), 0);
    chk("sat_count_b", 32'(out_count_b), 32'd3);
    chk("sat_err_b",   32'(out_err_b),   32'd1);
    chk("sat_tc_b",    32'(out_tc_b),    32'h1f);
    chk("sat_count_a", 32'(out_count_a), 32'd5);
    step(0, 0, 6'b0, 0, 1);

    // long frame saturates the 8-bit counter
    for (int i = 0; i < 270; i++)
      step(0, 1, therm($urandom_range(0, 6)), (i == 269), 1);
    chk("sat_count_a8", 32'(out_count_a), 32'd255);
    chk("sat_err_a8",   32'(out_err_a),   32'd1);

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 9) < 2);
      o = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 85) t = therm($urandom_range(0, 6));
      else t = 6'($urandom);
      step(r, v, t, l, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
